// File: rtl/count_display_pkg.sv
// Shared types, sizes and the 7-segment map for the count display.
// Holds the converter state enum, digit/BCD sizing and seg7_encode.
package count_display_pkg;

    localparam int unsigned CNT_W      = 7;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned BCD_W      = 12;
    localparam int unsigned ITERS      = 7;
    localparam int unsigned SHREG_W    = BCD_W + CNT_W;
    localparam int unsigned ITER_W     = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Active-high segments {g,f,e,d,c,b,a}; digits above 9 never occur and go dark.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/count_display_bin2bcd.sv
// Sequential shift-and-add-3 binary to BCD converter.
// Ports: clk, rst (async active-low), count (binary in),
//        bcd ({hundreds,tens,ones}, held between conversions), valid.
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   count,
    output logic [BCD_W-1:0]   bcd,
    output logic               valid
);

    conv_state_e          state_q, state_d;
    logic [CNT_W-1:0]     src_q, src_d;
    logic [SHREG_W-1:0]   shreg_q, shreg_d;
    logic [SHREG_W-1:0]   adj;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 valid_q, valid_d;
    logic                 start;

    // A new conversion is needed when the input moved or nothing is latched yet.
    assign start = (count != src_q) || !valid_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (iter_q == ITER_W'(ITERS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    always_comb begin
        adj = shreg_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (shreg_q[CNT_W + 4*i +: 4] >= 4'd5) begin
                adj[CNT_W + 4*i +: 4] = shreg_q[CNT_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath and outputs per state
    always_comb begin
        src_d   = src_q;
        shreg_d = shreg_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = count;
                    shreg_d = {BCD_W'(0), count};
                    iter_d  = '0;
                end
            end
            SHIFT: begin
                shreg_d = adj << 1;
                iter_d  = iter_q + ITER_W'(1);
            end
            DONE: begin
                bcd_d   = shreg_q[SHREG_W-1:CNT_W];
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q   <= '0;
            shreg_q <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            src_q   <= src_d;
            shreg_q <= shreg_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign bcd   = bcd_q;
    assign valid = valid_q;

endmodule

// File: rtl/count_display.sv
// Count display top: BCD conversion plus multiplexed 3-digit 7-segment drive
// with leading-zero blanking.
// Ports: clk, rst (async active-low), count (7-bit binary), bcd, valid,
//        seg {g..a} active-high, an digit enables (an[0]=ones .. an[2]=hundreds).
module count_display
    import count_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 10000
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   count,
    output logic [BCD_W-1:0]   bcd,
    output logic               valid,
    output logic [6:0]         seg,
    output logic [2:0]         an
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic [3:0]       nib;
    logic             show;
    logic [2:0]       an_sel;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .bcd   (bcd),
        .valid (valid)
    );

    // Prescaler and digit index
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Digit select with leading-zero blanking; ones always shown once valid.
    always_comb begin
        nib    = 4'd0;
        show   = 1'b0;
        an_sel = 3'b000;
        case (idx_q)
            2'd0: begin
                nib    = bcd[3:0];
                show   = 1'b1;
                an_sel = 3'b001;
            end
            2'd1: begin
                nib    = bcd[7:4];
                show   = (bcd[11:8] != 4'd0) || (bcd[7:4] != 4'd0);
                an_sel = 3'b010;
            end
            2'd2: begin
                nib    = bcd[11:8];
                show   = (bcd[11:8] != 4'd0);
                an_sel = 3'b100;
            end
            default: ;
        endcase
        seg_d = 7'h00;
        an_d  = 3'b000;
        if (valid && show) begin
            seg_d = seg7_encode(nib);
            an_d  = an_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display: behavioural model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_count_display;

    localparam int unsigned SCAN_DIV = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  count;
    logic [11:0] bcd;
    logic        valid;
    logic [6:0]  seg;
    logic [2:0]  an;

    int n_vec  = 0;
    int n_fail = 0;

    count_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .bcd   (bcd),
        .valid (valid),
        .seg   (seg),
        .an    (an)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_val   = 0;    // decimal value currently latched
    bit         m_valid = 0;
    bit         m_busy  = 0;
    int         m_left  = 0;
    int         m_src   = 0;
    int         m_edges = 0;
    logic [6:0] m_seg   = 0;
    logic [2:0] m_an    = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_val = 0; m_valid = 0; m_busy = 0; m_left = 0;
            m_src = 0; m_edges = 0; m_seg = 0; m_an = 0;
        end else begin
            int  slot;
            int  digit;
            bit  lit;
            // display registers sample the pre-edge slot and value
            slot  = (m_edges / SCAN_DIV) % 3;
            digit = (slot == 0) ? m_val % 10 : (slot == 1) ? (m_val / 10) % 10 : m_val / 100;
            lit   = m_valid && ((slot == 0) || (slot == 1 && m_val >= 10) || (slot == 2 && m_val >= 100));
            m_seg = lit ? SEG_TAB[digit] : 7'h00;
            m_an  = lit ? 3'(1 << slot) : 3'b000;
            m_edges++;
            // converter: sample, then result 8 edges later, ready again the edge after
            if (!m_busy) begin
                if ((int'(count) != m_src) || !m_valid) begin
                    m_src  = int'(count);
                    m_busy = 1;
                    m_left = 8;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_val   = m_src;
                    m_valid = 1;
                    m_busy  = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("bcd",   32'(bcd),   32'(to_bcd(m_val)));
        check("valid", 32'(valid), 32'(m_valid));
        check("seg",   32'(seg),   32'(m_seg));
        check("an",    32'(an),    32'(m_an));
        check("an_onehot", 32'($countones(an) <= 1), 32'd1);
    end

    // Advance n rising edges, landing 20 time units after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #20;
    endtask

    initial begin
        int          cnt_an [3];
        int          cnt_off;
        logic [11:0] seen [$];
        int          seen_at [$];
        logic [11:0] last;

        rst = 1'b0;
        count = 7'd0;
        tick(3);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_seg_an", 32'({seg, an}), 32'h0);
        rst = 1'b1;

        // First edge after release samples (edge 0); result lands 8 edges later.
        tick(8);
        check("init_valid_early", 32'(valid), 32'h0);
        tick(1);
        check("init_valid", 32'(valid), 32'h1);
        check("init_bcd", 32'(bcd), 32'h000);
        for (int i = 0; i < 3 * SCAN_DIV * 2; i++) begin
            tick(1);
            check("zero_an", 32'(an == 3'b001 || an == 3'b000), 32'h1);
            if (an == 3'b001) check("zero_seg", 32'(seg), 32'h3F);
        end

        // 99
        count = 7'd99;
        tick(8);
        check("b99_early", 32'(bcd), 32'h000);
        tick(1);
        check("b99", 32'(bcd), 32'h099);
        tick(2);
        cnt_off = 0;
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            tick(1);
            if (an == 3'b000) cnt_off++;
            else check("b99_seg", 32'(seg), 32'h6F);
            check("b99_no_hund", 32'(an == 3'b100), 32'h0);
        end
        check("b99_blank_slot", 32'(cnt_off), 32'(SCAN_DIV));

        // 127
        count = 7'd127;
        tick(9);
        check("b127", 32'(bcd), 32'h127);
        tick(2);
        cnt_an = '{0, 0, 0};
        for (int i = 0; i < 6 * SCAN_DIV; i++) begin
            tick(1);
            case (an)
                3'b001: begin cnt_an[0]++; check("b127_ones", 32'(seg), 32'h07); end
                3'b010: begin cnt_an[1]++; check("b127_tens", 32'(seg), 32'h5B); end
                3'b100: begin cnt_an[2]++; check("b127_hund", 32'(seg), 32'h06); end
                default: check("b127_an", 32'(an), 32'h1);
            endcase
        end
        for (int d = 0; d < 3; d++) check("b127_slot_len", 32'(cnt_an[d]), 32'(2 * SCAN_DIV));

        // 5 then 42 three cycles later: only 005 then 042 may appear
        count = 7'd5;
        tick(3);
        count = 7'd42;
        last = bcd;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bcd != last) begin
                seen.push_back(bcd);
                seen_at.push_back(i);
                last = bcd;
            end
        end
        check("skip_n", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("skip_first", 32'(seen[0]), 32'h005);
            check("skip_second", 32'(seen[1]), 32'h042);
            check("skip_gap", 32'(seen_at[1] - seen_at[0] <= 9), 32'h1);
        end

        // Counter sweep, slow enough that every value converts
        for (int v = 0; v < 128; v++) begin
            count = 7'(v);
            tick(16);
        end

        // Random count changes, including faster than a conversion
        for (int i = 0; i < 300; i++) begin
            count = 7'($urandom_range(0, 127));
            tick($urandom_range(1, 12));
        end
        tick(12);

        // Async reset in the middle of converting 100
        count = 7'd1;
        tick(12);
        count = 7'd100;
        tick(3);
        rst = 1'b0;
        #1;
        check("arst_bcd", 32'(bcd), 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        check("arst_seg", 32'(seg), 32'h0);
        check("arst_an", 32'(an), 32'h0);
        tick(2);
        rst = 1'b1;
        tick(8);
        check("rel_valid_early", 32'(valid), 32'h0);
        tick(1);
        check("rel_bcd", 32'(bcd), 32'h100);
        check("rel_valid", 32'(valid), 32'h1);
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
